softmax_job_arbiter: RTL and testbench
======================================

// Module: softmax_job_arbiter
// PURPOSE
//  Shares one softmax_core (BRAM + BRAM_FSM + softmax_approx) between NUM_REQ requesters.
//  - Round-robin lease arbiter. The lease owner's BRAM port A/B bundle is muxed to the core's external ports.
//  - Forwards the owner's start request as a single-cycle core start.
//  - Tracks core busy and returns a per-requester done pulse.
//  - Flags a core that never starts or runs too long.
// PARAMETERS
//  NUM_REQ     4     number of requesters (2..8); IDX_W = $clog2(NUM_REQ)
//  ADDR_W      5     BRAM address width
//  DATA_W      1028  BRAM word width
//  START_TO    4     cycles to wait for i_core_busy to rise after o_core_start
//  RUN_TO      4096  busy cycles before run-timeout flag; 16-bit counter
// PORTS
//  i_clk          in   1               clock, all logic on rising edge
//  i_rst_n        in   1               asynchronous active-low reset
//  i_req          in   NUM_REQ         lease request, level, one bit per requester
//  o_gnt          out  NUM_REQ         lease grant, registered, one-hot or zero
//  i_go           in   NUM_REQ         run request from a requester, sampled only from the owner
//  o_done         out  NUM_REQ         1-cycle pulse to the owner when its run ends
//  i_cena         in   NUM_REQ         per-requester port A enable
//  i_wea          in   NUM_REQ         per-requester port A write enable
//  i_addra        in   NUM_REQ*ADDR_W  per-requester port A address, flattened, requester k at [k*ADDR_W +: ADDR_W]
//  i_dina         in   NUM_REQ*DATA_W  per-requester port A data, flattened likewise
//  i_cenb         in   NUM_REQ         per-requester port B enable
//  i_addrb        in   NUM_REQ*ADDR_W  per-requester port B address, flattened
//  o_core_cena    out  1               to core i_ext_cena
//  o_core_wea     out  1               to core i_ext_wea
//  o_core_addra   out  ADDR_W          to core i_ext_addra
//  o_core_dina    out  DATA_W          to core i_ext_dina
//  o_core_cenb    out  1               to core i_ext_cenb
//  o_core_addrb   out  ADDR_W          to core i_ext_addrb
//  o_core_start   out  1               to core i_start, registered 1-cycle pulse
//  i_core_busy    in   1               from core o_busy
//  o_owner        out  IDX_W           index of the current owner; valid while |o_gnt
//  o_err          out  2               sticky flags: [0] start timeout, [1] run timeout
//  i_err_clr      in   1               synchronous clear of o_err
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE, rr_ptr=0, counters=0.
//   All registered outputs are 0: o_gnt, o_done, o_core_start, o_owner, o_err.
//   No owner, so every muxed core-port output is 0.
//  Read data is not handled here; requesters tap core o_ext_doutb directly.
//  Mux: core-port outputs = owner's bundle only in OWN; 0 in every other state.
//   Purely combinational from the registered owner index.
//  FSM:
//   IDLE : on the edge where any i_req=1 and i_core_busy=0:
//          winner = first set i_req scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//          -> OWN; o_gnt[winner]=1; o_owner=winner; rr_ptr=(winner+1)%NUM_REQ.
//          While i_core_busy=1 (e.g. core still running after a reset), no grant is issued.
//   OWN  : owner has the BRAM ports.
//          i_req[owner]=0 -> IDLE, o_gnt=0 next cycle (release).
//          Else i_go[owner]=1 -> START_WAIT, o_core_start=1 for exactly the next cycle.
//          Release wins over go when both occur in the same cycle.
//   START_WAIT : count cycles.
//          i_core_busy=1 -> RUN.
//          Count reaches START_TO with busy still 0 -> o_err[0]=1 -> DONE.
//   RUN  : count busy cycles.
//          Count reaches RUN_TO -> o_err[1]=1 (once); keep waiting, the core is never aborted.
//          i_core_busy=0 -> DONE.
//   DONE : o_done[owner]=1 for this one cycle -> OWN. o_gnt is held throughout.
//  i_req[owner] dropped in START_WAIT/RUN/DONE: deferred; the release is taken in OWN.
//  i_go from non-owners, and i_go outside OWN: ignored, not queued.
//  Requests changing in the same cycle as a grant: only the sampled edge matters.
//  i_err_clr: clears o_err; a flag set in the same cycle wins over the clear.
//  Latency: i_req rise to o_gnt = 1 edge; i_go to o_core_start = 1 edge;
//   i_core_busy fall to o_done = 1 edge.
//  Fairness: the just-served requester has lowest priority at the next arbitration.
// TESTING
//  1. Reset, i_req=4'b0101 held -> o_gnt=4'b0001 one edge later; o_owner=0.
//     Drop i_req[0] -> o_gnt=4'b0100 within 2 edges.
//  2. Owner 2 writes addra=5'd3 with dina=pattern -> appears on o_core_* the same cycle.
//     Requester 1 toggling its own i_cena/i_wea -> core ports unchanged.
//  3. Owner i_go pulse; model busy high 20 cycles -> exactly one o_core_start cycle.
//     One o_done[owner] pulse 1 edge after busy falls; o_err=0.
//  4. i_go with busy never rising -> o_err[0]=1 after START_TO=4 cycles, o_done pulse.
//     i_err_clr -> o_err=0.
//  5. i_req=4'b1111 held, each owner releases after one run -> grant order 0,1,2,3,0.
//     Drop i_req mid-RUN -> grant held until after o_done.
//  6. Assert i_rst_n=0 mid-RUN with busy held high -> all outputs 0 immediately.
//     After release, no grant while busy=1; grant 1 edge after busy falls.

Source files
------------

// File: rtl/softmax_job_arbiter.sv
// Round-robin lease arbiter sharing one softmax_core between NUM_REQ requesters:
// muxes the owner's BRAM ports, forwards its start, returns done, flags timeouts.
module softmax_job_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 1028,
    parameter int START_TO = 4,
    parameter int RUN_TO   = 4096,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    output logic [NUM_REQ-1:0]        o_gnt,
    input  logic [NUM_REQ-1:0]        i_go,
    output logic [NUM_REQ-1:0]        o_done,
    input  logic [NUM_REQ-1:0]        i_cena,
    input  logic [NUM_REQ-1:0]        i_wea,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addra,
    input  logic [NUM_REQ*DATA_W-1:0] i_dina,
    input  logic [NUM_REQ-1:0]        i_cenb,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addrb,
    output logic                      o_core_cena,
    output logic                      o_core_wea,
    output logic [ADDR_W-1:0]         o_core_addra,
    output logic [DATA_W-1:0]         o_core_dina,
    output logic                      o_core_cenb,
    output logic [ADDR_W-1:0]         o_core_addrb,
    output logic                      o_core_start,
    input  logic                      i_core_busy,
    output logic [IDX_W-1:0]          o_owner,
    output logic [1:0]                o_err,
    input  logic                      i_err_clr
);

    typedef enum logic [2:0] {S_IDLE, S_OWN, S_START_WAIT, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 start_q, start_d;
    logic [1:0]           err_q, err_d, err_set;
    logic [15:0]          cnt_q, cnt_d;

    logic [IDX_W:0]       scan;
    logic [IDX_W-1:0]     win, win_next;
    logic                 found;

    // Scan downward so the candidate closest to rr_q is the last one written.
    always_comb begin
        scan  = '0;
        win   = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (scan >= (IDX_W+1)'(NUM_REQ))
                scan = scan - (IDX_W+1)'(NUM_REQ);
            if (i_req[scan[IDX_W-1:0]]) begin
                win   = scan[IDX_W-1:0];
                found = 1'b1;
            end
        end
        win_next = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        start_d = 1'b0;
        cnt_d   = cnt_q;
        err_set = '0;
        case (state_q)
            S_IDLE: begin
                if (found && !i_core_busy) begin
                    state_d = S_OWN;
                    gnt_d   = NUM_REQ'(1) << win;
                    owner_d = win;
                    rr_d    = win_next;
                end
            end
            S_OWN: begin
                if (!i_req[owner_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else if (i_go[owner_q]) begin
                    state_d = S_START_WAIT;
                    start_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_START_WAIT: begin
                if (i_core_busy) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == 16'(START_TO - 1)) begin
                    err_set[0] = 1'b1;
                    state_d    = S_DONE;
                    done_d     = NUM_REQ'(1) << owner_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RUN: begin
                if (!i_core_busy) begin
                    state_d = S_DONE;
                    done_d  = NUM_REQ'(1) << owner_q;
                end else begin
                    // Counter parks at RUN_TO so the flag is raised only once per run.
                    if (cnt_q == 16'(RUN_TO - 1))
                        err_set[1] = 1'b1;
                    if (cnt_q != 16'(RUN_TO))
                        cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_OWN;
            default: state_d = S_IDLE;
        endcase
        err_d = (i_err_clr ? 2'b00 : err_q) | err_set;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            start_q <= start_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Core ports follow the owner only while it actually holds the lease in OWN.
    always_comb begin
        o_core_cena  = 1'b0;
        o_core_wea   = 1'b0;
        o_core_addra = '0;
        o_core_dina  = '0;
        o_core_cenb  = 1'b0;
        o_core_addrb = '0;
        if (state_q == S_OWN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (owner_q == IDX_W'(k)) begin
                    o_core_cena  = i_cena[k];
                    o_core_wea   = i_wea[k];
                    o_core_addra = i_addra[k*ADDR_W +: ADDR_W];
                    o_core_dina  = i_dina[k*DATA_W +: DATA_W];
                    o_core_cenb  = i_cenb[k];
                    o_core_addrb = i_addrb[k*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    assign o_gnt        = gnt_q;
    assign o_done       = done_q;
    assign o_core_start = start_q;
    assign o_owner      = owner_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_softmax_job_arbiter.sv
// Directed bench for softmax_job_arbiter: lease, mux, start/done, timeouts, fairness, reset.
module tb_softmax_job_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 1028;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req, go, cena, wea, cenb;
    logic [NUM_REQ*ADDR_W-1:0] addra, addrb;
    logic [NUM_REQ*DATA_W-1:0] dina;
    logic                      busy, err_clr;
    logic [NUM_REQ-1:0]        gnt, done;
    logic                      core_cena, core_wea, core_cenb, core_start;
    logic [ADDR_W-1:0]         core_addra, core_addrb;
    logic [DATA_W-1:0]         core_dina;
    logic [1:0]                owner, err;

    logic [DATA_W-1:0]         pat;
    int                        vectors = 0;
    int                        miscompares = 0;
    int                        start_seen, done_seen;

    softmax_job_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .START_TO(4), .RUN_TO(4096)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_gnt(gnt), .i_go(go), .o_done(done),
        .i_cena(cena), .i_wea(wea), .i_addra(addra), .i_dina(dina), .i_cenb(cenb), .i_addrb(addrb),
        .o_core_cena(core_cena), .o_core_wea(core_wea), .o_core_addra(core_addra),
        .o_core_dina(core_dina), .o_core_cenb(core_cenb), .o_core_addrb(core_addrb),
        .o_core_start(core_start), .i_core_busy(busy), .o_owner(owner), .o_err(err),
        .i_err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One go/run/done cycle for the current owner, busy held for run_len cycles.
    task automatic run_job(input int o, input int run_len);
        go[o] = 1'b1;
        tick();
        go    = '0;
        busy  = 1'b1;
        tick(run_len);
        busy  = 1'b0;
        tick();
        check("job_done", done, 64'(4'b0001 << o));
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req = '0; go = '0; cena = '0; wea = '0; cenb = '0;
        addra = '0; addrb = '0; dina = '0; busy = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < DATA_W; i++) pat[i] = (i % 3 == 0) ^ (i % 7 == 2);

        tick(2);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_start", core_start, 0);
        check("rst_owner", owner, 0);
        check("rst_err", err, 0);
        check("rst_cena", core_cena, 0);
        rst_n = 1'b1;

        // 1. First arbitration and hand-over
        req = 4'b0101;
        tick();
        check("t1_gnt0", gnt, 4'b0001);
        check("t1_owner0", owner, 0);
        req = 4'b0100;
        tick();
        check("t1_release", gnt, 4'b0000);
        tick();
        check("t1_gnt2", gnt, 4'b0100);
        check("t1_owner2", owner, 2);

        // 2. Port mux follows owner 2 combinationally, ignores requester 1
        cena[2] = 1'b1; wea[2] = 1'b1; cenb[2] = 1'b1;
        addra[2*ADDR_W +: ADDR_W] = 5'd3;
        addrb[2*ADDR_W +: ADDR_W] = 5'd7;
        dina[2*DATA_W +: DATA_W]  = pat;
        #1;
        check("t2_cena", core_cena, 1);
        check("t2_wea", core_wea, 1);
        check("t2_addra", core_addra, 3);
        check("t2_dina_lo", core_dina[63:0], pat[63:0]);
        check("t2_dina_hi", core_dina[DATA_W-1 -: 64], pat[DATA_W-1 -: 64]);
        check("t2_cenb", core_cenb, 1);
        check("t2_addrb", core_addrb, 7);
        cena[2] = 1'b0; wea[2] = 1'b0;
        cena[1] = 1'b1; wea[1] = 1'b1;
        addra[1*ADDR_W +: ADDR_W] = 5'd9;
        #1;
        check("t2_other_cena", core_cena, 0);
        check("t2_other_wea", core_wea, 0);
        check("t2_other_addra", core_addra, 3);
        cena = '0; wea = '0; cenb = '0;

        // 3. Normal run, busy 20 cycles
        go[2] = 1'b1;
        tick();
        check("t3_start", core_start, 1);
        go = '0; busy = 1'b1;
        tick();
        check("t3_start_once", core_start, 0);
        start_seen = 0; done_seen = 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            start_seen += int'(core_start);
            done_seen  += int'(|done);
        end
        check("t3_no_extra_start", 64'(start_seen), 0);
        check("t3_no_early_done", 64'(done_seen), 0);
        busy = 1'b0;
        tick();
        check("t3_done", done, 4'b0100);
        check("t3_gnt_held", gnt, 4'b0100);
        tick();
        check("t3_done_pulse", done, 0);
        check("t3_err", err, 0);

        // 4. Start timeout
        go[2] = 1'b1;
        tick();
        go = '0;
        tick(3);
        check("t4_err_not_early", err, 0);
        tick();
        check("t4_err_start", err, 2'b01);
        check("t4_done", done, 4'b0100);
        tick();
        check("t4_err_sticky", err, 2'b01);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_err_clr", err, 0);

        // Run timeout, core never aborted
        go[2] = 1'b1;
        tick();
        go = '0; busy = 1'b1;
        tick(4001);
        check("rt_err_not_early", err, 0);
        tick(200);
        check("rt_err_run", err, 2'b10);
        check("rt_no_done", done, 0);
        busy = 1'b0;
        tick();
        check("rt_done", done, 4'b0100);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("rt_err_clr", err, 0);

        // 5. Fairness with all requesting; release dropped mid-RUN is deferred
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        check("t5_first", gnt, 4'b0001);
        for (int o = 0; o < NUM_REQ; o++) begin
            go[o] = 1'b1;
            tick();
            go = '0; busy = 1'b1; req[o] = 1'b0;
            tick(2);
            check("t5_held_run", gnt, 64'(4'b0001 << o));
            busy = 1'b0;
            tick();
            check("t5_done", done, 64'(4'b0001 << o));
            check("t5_held_done", gnt, 64'(4'b0001 << o));
            tick();
            check("t5_held_own", gnt, 64'(4'b0001 << o));
            tick();
            check("t5_release", gnt, 0);
            req[o] = 1'b1;
            tick();
            check("t5_next", gnt, 64'(4'b0001 << ((o + 1) % NUM_REQ)));
        end

        // 6. Reset mid-RUN with core still busy
        run_job(0, 3);
        cena = '1;
        go[0] = 1'b1;
        tick();
        go = '0; busy = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        check("t6_gnt", gnt, 0);
        check("t6_owner", owner, 0);
        check("t6_start", core_start, 0);
        check("t6_done", done, 0);
        check("t6_err", err, 0);
        check("t6_cena", core_cena, 0);
        rst_n = 1'b1;
        tick(3);
        check("t6_no_gnt_busy", gnt, 0);
        busy = 1'b0;
        tick();
        check("t6_gnt_after_busy", gnt, 4'b0001);
        check("t6_cena_owner", core_cena, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
